// File: rtl/ai_car_spawn_scheduler.sv
// Spawn scheduler for the AI car bank: finds a free car slot and an unblocked lane,
// then hands one spawn command per grant to the controllers over valid/ack.
module ai_car_spawn_scheduler #(
    parameter int unsigned NUM_CARS    = 4,
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned LANE_X0     = 180,
    parameter int unsigned LANE_PITCH  = 60,
    parameter int unsigned OFFSCREEN_Y = 480,
    parameter int unsigned SAFE_Y      = 128,
    parameter int unsigned SPAWN_GAP   = 32,
    parameter int unsigned MIN_GAP     = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      frame_start,
    input  logic [0:10]               random,
    input  logic [0:9]                player_speed,
    input  logic [0:NUM_CARS-1][0:10] car_y,
    input  logic                      spawn_ack,
    output logic                      spawn_valid,
    output logic [1:0]                spawn_id,
    output logic [10:0]               spawn_x,
    output logic [1:0]                spawn_lane,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, SCAN, PROBE, ISSUE} state_t;

    state_t                     r_state,       w_state_nx;
    logic [1:0]                 r_scan_idx,    w_scan_idx_nx;
    logic [1:0]                 r_probe_lane,  w_probe_lane_nx;
    logic [1:0]                 r_probe_cnt,   w_probe_cnt_nx;
    logic [10:0]                r_cooldown,    w_cooldown_nx;
    logic                       r_spawn_valid, w_spawn_valid_nx;
    logic [1:0]                 r_spawn_id,    w_spawn_id_nx;
    logic [10:0]                r_spawn_x,     w_spawn_x_nx;
    logic [1:0]                 r_spawn_lane,  w_spawn_lane_nx;
    logic [NUM_CARS-1:0]        r_lane_valid,  w_lane_valid_nx;
    logic [NUM_CARS-1:0][1:0]   r_lane_of,     w_lane_of_nx;

    logic [NUM_LANES-1:0]       w_lane_blocked;
    logic [10:0]                w_speed_div;
    logic [10:0]                w_gap_sub;
    logic [10:0]                w_reload;

    // Faster player -> shorter cooldown, saturating at zero before the MIN_GAP floor.
    always_comb begin
        w_speed_div = 11'(player_speed) >> 6;
        w_gap_sub   = (11'(SPAWN_GAP) > w_speed_div) ? 11'(SPAWN_GAP) - w_speed_div : '0;
        w_reload    = (w_gap_sub > 11'(MIN_GAP)) ? w_gap_sub : 11'(MIN_GAP);
    end

    always_comb begin
        w_lane_blocked = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned c = 0; c < NUM_CARS; c++) begin
                if (r_lane_valid[c] && (r_lane_of[c] == 2'(l)) && (car_y[c] < 11'(SAFE_Y)))
                    w_lane_blocked[l] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_scan_idx_nx    = r_scan_idx;
        w_probe_lane_nx  = r_probe_lane;
        w_probe_cnt_nx   = r_probe_cnt;
        w_spawn_valid_nx = r_spawn_valid;
        w_spawn_id_nx    = r_spawn_id;
        w_spawn_x_nx     = r_spawn_x;
        w_spawn_lane_nx  = r_spawn_lane;
        w_lane_of_nx     = r_lane_of;
        w_cooldown_nx    = (frame_start && (r_cooldown != '0)) ? r_cooldown - 11'd1 : r_cooldown;
        w_lane_valid_nx  = r_lane_valid;
        for (int unsigned c = 0; c < NUM_CARS; c++) begin
            if (car_y[c] >= 11'(OFFSCREEN_Y))
                w_lane_valid_nx[c] = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (frame_start && (r_cooldown == '0)) begin
                    w_state_nx    = SCAN;
                    w_scan_idx_nx = '0;
                end
            end
            SCAN: begin
                if (car_y[r_scan_idx] >= 11'(OFFSCREEN_Y)) begin
                    w_spawn_id_nx   = r_scan_idx;
                    w_probe_cnt_nx  = '0;
                    w_probe_lane_nx = random[9:10];
                    w_state_nx      = PROBE;
                end else if (r_scan_idx == 2'(NUM_CARS - 1)) begin
                    w_state_nx = IDLE;
                end else begin
                    w_scan_idx_nx = r_scan_idx + 2'd1;
                end
            end
            PROBE: begin
                if (!w_lane_blocked[r_probe_lane]) begin
                    w_spawn_lane_nx  = r_probe_lane;
                    w_spawn_x_nx     = 11'(LANE_X0) + 11'(r_probe_lane) * 11'(LANE_PITCH);
                    w_spawn_valid_nx = 1'b1;
                    w_state_nx       = ISSUE;
                end else if (r_probe_cnt == 2'(NUM_LANES - 1)) begin
                    w_state_nx = IDLE;
                end else begin
                    w_probe_lane_nx = (r_probe_lane == 2'(NUM_LANES - 1)) ? '0 : r_probe_lane + 2'd1;
                    w_probe_cnt_nx  = r_probe_cnt + 2'd1;
                end
            end
            ISSUE: begin
                // Ack overrides both the offscreen clear and the frame decrement.
                if (spawn_ack) begin
                    w_lane_of_nx[r_spawn_id]    = r_spawn_lane;
                    w_lane_valid_nx[r_spawn_id] = 1'b1;
                    w_cooldown_nx               = w_reload;
                    w_spawn_valid_nx            = 1'b0;
                    w_state_nx                  = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE;
            r_scan_idx    <= '0;
            r_probe_lane  <= '0;
            r_probe_cnt   <= '0;
            r_cooldown    <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_id    <= '0;
            r_spawn_x     <= '0;
            r_spawn_lane  <= '0;
            r_lane_valid  <= '0;
            r_lane_of     <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_scan_idx    <= w_scan_idx_nx;
            r_probe_lane  <= w_probe_lane_nx;
            r_probe_cnt   <= w_probe_cnt_nx;
            r_cooldown    <= w_cooldown_nx;
            r_spawn_valid <= w_spawn_valid_nx;
            r_spawn_id    <= w_spawn_id_nx;
            r_spawn_x     <= w_spawn_x_nx;
            r_spawn_lane  <= w_spawn_lane_nx;
            r_lane_valid  <= w_lane_valid_nx;
            r_lane_of     <= w_lane_of_nx;
        end
    end

    assign spawn_valid = r_spawn_valid;
    assign spawn_id    = r_spawn_id;
    assign spawn_x     = r_spawn_x;
    assign spawn_lane  = r_spawn_lane;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ai_car_spawn_scheduler.sv
// Directed bench for ai_car_spawn_scheduler: a carried-state vector table plus
// hand sequences for cooldown scaling, ack/frame collision and async reset.
module tb_ai_car_spawn_scheduler;

    logic               clk = 1'b0;
    logic               resetN;
    logic               frame_start;
    logic [0:10]        random;
    logic [0:9]         player_speed;
    logic [0:3][0:10]   car_y;
    logic               spawn_ack;
    logic               spawn_valid;
    logic [1:0]         spawn_id;
    logic [10:0]        spawn_x;
    logic [1:0]         spawn_lane;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cd       = 0;

    ai_car_spawn_scheduler #(
        .NUM_CARS(4), .NUM_LANES(4), .LANE_X0(180), .LANE_PITCH(60),
        .OFFSCREEN_Y(480), .SAFE_Y(128), .SPAWN_GAP(32), .MIN_GAP(8)
    ) dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start), .random(random),
        .player_speed(player_speed), .car_y(car_y), .spawn_ack(spawn_ack),
        .spawn_valid(spawn_valid), .spawn_id(spawn_id), .spawn_x(spawn_x),
        .spawn_lane(spawn_lane), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][10:0] yv;
        logic [10:0]      rnd;
        bit               spawn;
        int               lat;   // spawn latency, or busy cycles when no spawn
        logic [1:0]       id;
        logic [1:0]       lane;
        logic [10:0]      x;
    } vec_t;

    vec_t tbl [6];

    function automatic vec_t mk(int y0, int y1, int y2, int y3, int rnd, bit sp,
                                int lat, int id, int lane, int x);
        vec_t v;
        v.yv[0] = 11'(y0); v.yv[1] = 11'(y1); v.yv[2] = 11'(y2); v.yv[3] = 11'(y3);
        v.rnd = 11'(rnd); v.spawn = sp; v.lat = lat;
        v.id = 2'(id); v.lane = 2'(lane); v.x = 11'(x);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!spawn_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_ack(input bit with_frame);
        spawn_ack   = 1'b1;
        frame_start = with_frame;
        @(posedge clk); #1;
        spawn_ack   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frames_to_start(output int n);
        n = 0;
        while (!busy && n < 60) begin
            pulse_frame();
            n++;
            if (!busy) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int  lat, n;
        bit  ok, saw;
        logic [1:0] id;

        resetN = 1'b0; frame_start = 1'b0; random = '0; player_speed = '0;
        car_y = '{default: 11'd480}; spawn_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", spawn_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_id",    spawn_id, 0);
        check("rst_x",     spawn_x, 0);
        check("rst_lane",  spawn_lane, 0);
        resetN = 1'b1;

        tbl[0] = mk(480, 480, 480, 480, 0, 1, 3, 0, 0, 180);
        tbl[1] = mk(127, 480, 480, 480, 0, 1, 5, 1, 1, 240);
        tbl[2] = mk( 50,  60, 480, 480, 3, 1, 5, 2, 3, 360);
        tbl[3] = mk( 50,  60,  70, 480, 3, 1, 9, 3, 2, 300);
        tbl[4] = mk( 50,  60,  70, 479, 1, 0, 4, 0, 0,   0);
        tbl[5] = mk(128,  60,  70, 480, 0, 1, 6, 3, 0, 180);

        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) car_y[c] = tbl[v].yv[c];
            random = tbl[v].rnd;
            @(posedge clk); #1;

            ok = 1'b1;
            for (int k = 0; k < cd; k++) begin
                pulse_frame();
                if (busy) ok = 1'b0;
                @(posedge clk); #1;
            end
            cd = 0;
            check($sformatf("v%0d_drain_idle", v), ok, 1);

            // Ack while idle must not touch the cooldown.
            spawn_ack = 1'b1;
            @(posedge clk); #1;
            spawn_ack = 1'b0;

            pulse_frame();
            if (tbl[v].spawn) begin
                wait_valid(lat);
                check($sformatf("v%0d_latency", v), lat, tbl[v].lat);
                check($sformatf("v%0d_id", v),   spawn_id,   tbl[v].id);
                check($sformatf("v%0d_lane", v), spawn_lane, tbl[v].lane);
                check($sformatf("v%0d_x", v),    spawn_x,    tbl[v].x);
                ok = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    random = 11'($urandom);
                    @(posedge clk); #1;
                    if (!spawn_valid || spawn_id != tbl[v].id || spawn_lane != tbl[v].lane ||
                        spawn_x != tbl[v].x) ok = 1'b0;
                end
                check($sformatf("v%0d_hold", v), ok, 1);
                do_ack(1'b0);
                car_y[tbl[v].id] = 11'd0;
                cd = 32;
                check($sformatf("v%0d_ack_valid", v), spawn_valid, 0);
                check($sformatf("v%0d_ack_busy", v),  busy, 0);
            end else begin
                n = 0; saw = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    if (busy) n++;
                    if (spawn_valid) saw = 1'b1;
                    @(posedge clk); #1;
                end
                check($sformatf("v%0d_busy_cycles", v), n, tbl[v].lat);
                check($sformatf("v%0d_no_spawn", v), saw, 0);
            end
        end

        // Cooldown scaling with player speed, and ack colliding with frame_start.
        random = '0;
        player_speed = 10'd1023;
        car_y = '{default: 11'd480};
        @(posedge clk); #1;
        for (int k = 0; k < cd; k++) begin
            pulse_frame();
            @(posedge clk); #1;
        end
        pulse_frame();
        wait_valid(lat);
        check("fast_latency", lat, 3);
        check("fast_id", spawn_id, 0);
        do_ack(1'b1);
        car_y[0] = 11'd50;
        frames_to_start(n);
        check("reload_fast_frames", n, 18);
        wait_valid(lat);
        check("fast2_id", spawn_id, 1);
        check("fast2_lane", spawn_lane, 1);
        player_speed = '0;
        do_ack(1'b0);
        car_y[1] = 11'd50;
        frames_to_start(n);
        check("reload_slow_frames", n, 33);
        wait_valid(lat);
        check("slow_lane", spawn_lane, 2);
        id = spawn_id;
        check("slow_id", id, 2);

        // Reset in the middle of ISSUE.
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_valid", spawn_valid, 0);
        check("async_rst_busy", busy, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        pulse_frame();
        wait_valid(lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_id", spawn_id, 2);
        check("post_rst_lane", spawn_lane, 0);
        check("post_rst_x", spawn_x, 180);
        do_ack(1'b0);
        check("post_rst_ack_valid", spawn_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
